ram2_arbiter: RTL and testbench
===============================

# ram2_arbiter

Sequencing controller and two-port arbiter for the external RAM2 SRAM of the 16-bit CPU. It shares the single asynchronous SRAM between the instruction-fetch port (IF) and the memory-stage port (MEM). Each granted access runs as a multi-cycle SETUP/STROBE/HOLD sequence with glitch-free active-low strobes. The block returns read data and a one-cycle acknowledge per access, and sits between the pipeline and the board-level Ram2 pins.

## Interface
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- WAIT_CYCLES, 1, extra STROBE cycles (range 1..15); only used with RAM2_WAIT_EN
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- if_req_i  in  1  IF read request, level; held until if_ack_o
- if_addr_i  in  16  IF word address, zero-extended to ADDR_W
- if_data_o  out  DATA_W  IF read data, registered
- if_ack_o  out  1  one-cycle pulse: IF access complete
- mem_req_i  in  1  MEM request, level; held until mem_ack_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  ADDR_W  MEM address
- mem_wdata_i  in  DATA_W  MEM write data
- mem_rdata_o  out  DATA_W  MEM read data, registered
- mem_ack_o  out  1  one-cycle pulse: MEM access complete
- busy_o  out  1  high in every state except IDLE
- Ram2Addr_o  out  ADDR_W  SRAM address, registered
- Ram2Data_io  inout  DATA_W  SRAM data bus
- Ram2OE_o, Ram2WE_o, Ram2EN_o  out  1 each  SRAM strobes, active-low, registered

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- Grant points are IDLE and HOLD. At a grant point:
  - Sample the requests.
  - Latch the winner's address, write data and direction into internal registers.
  - Go to SETUP. If no request is pending, go to IDLE.
- Arbitration:
  - Only one request pending: that port wins.
  - Both pending: the port not granted last wins.
  - The last-grant register resets to IF, so MEM wins the first tie.
- SETUP: Ram2Addr_o = latched address; Ram2EN_o = 0; Ram2OE_o = 1; Ram2WE_o = 1.
  - For a write, the bus drives the latched write data.
- STROBE:
  - Read: Ram2OE_o = 0.
  - Write: Ram2WE_o = 0.
  - Address and data stay stable.
  - At the edge leaving STROBE, a read captures Ram2Data_io into the granted port's rdata register.
- HOLD:
  - Both strobes are 1; address and write data are still held.
  - The granted port's ack is 1 for this cycle only.
  - Ram2EN_o stays 0 if the next state is SETUP; otherwise it returns to 1 in IDLE.
- Ram2Data_io is driven only in SETUP, STROBE and HOLD of a write; it is Z at all other times.
- An IF access never drives the bus and never asserts Ram2WE_o.
- A granted access always completes, even if its request drops early.
- Read data registers hold their value until the next read ack on the same port.
- A request still high in the cycle of its own ack counts as a new request.

## Timing
- Reset (async, rst = 0):
  - State = IDLE; last-grant = IF.
  - Ram2EN_o = Ram2OE_o = Ram2WE_o = 1; Ram2Addr_o = 0; Ram2Data_io = Z.
  - if_ack_o = mem_ack_o = 0; if_data_o = mem_rdata_o = 0; busy_o = 0.
- Reset mid-access: the access is aborted, no ack is issued, and the strobes deassert immediately (asynchronously).
- Request sampled in IDLE at edge k: SETUP in cycle k+1, STROBE in k+2, HOLD/ack in k+3. Base latency is 3 cycles.
- Back-to-back accesses go HOLD → SETUP directly, giving one access per 3 cycles.
- Each strobe is low for exactly one cycle. Address/data setup and hold are one full cycle each.
- All SRAM pins are register outputs with no combinational path from clk.

## Configuration
- Macro: RAM2_WAIT_EN.
- Defined:
  - STROBE lasts 1 + WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded on entry to STROBE.
  - Read capture occurs on the final STROBE edge.
  - Latency becomes 3 + WAIT_CYCLES.
- Undefined:
  - STROBE is a single cycle; WAIT_CYCLES is ignored and no counter is built.

## Test plan
- IF read, addr 0x0040, SRAM model word 0x1234 → if_ack_o pulses at k+3; if_data_o = 0x1234; Ram2OE_o low exactly 1 cycle; Ram2WE_o high throughout; bus Z throughout.
- MEM write, addr 0x20010, data 0xBEEF → Ram2WE_o low 1 cycle; bus = 0xBEEF from SETUP through HOLD, then Z; model holds 0xBEEF; mem_ack_o at k+3.
- IF and MEM both requested in the first cycle after reset → MEM granted first; IF follows HOLD → SETUP with no IDLE; if_ack_o comes 3 cycles after mem_ack_o.
- Both requests held for 4 accesses → grant order MEM, IF, MEM, IF; busy_o continuously high; no extra ack pulses.
- rst driven low during STROBE of a write → Ram2WE_o, Ram2OE_o and Ram2EN_o go to 1 and the bus goes to Z immediately; no mem_ack_o; IDLE after release; a new request then completes normally.
- RAM2_WAIT_EN defined, WAIT_CYCLES = 2, MEM read returning 0x5A5A → Ram2OE_o low 3 cycles; mem_ack_o at k+5; mem_rdata_o = 0x5A5A.

Source files
------------

// File: rtl/ram2_arbiter_if.sv
// Pipeline-side request/acknowledge bundle of the RAM2 arbiter.
// slave  : the arbiter's view (requests in, read data / acks out).
// master : the pipeline's view.
interface ram2_arbiter_if #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 16
);
   logic              if_req_i;
   logic [15:0]       if_addr_i;
   logic [DATA_W-1:0] if_data_o;
   logic              if_ack_o;

   logic              mem_req_i;
   logic              mem_we_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [DATA_W-1:0] mem_wdata_i;
   logic [DATA_W-1:0] mem_rdata_o;
   logic              mem_ack_o;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_data_o, if_ack_o,
      input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
      output mem_rdata_o, mem_ack_o
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_data_o, if_ack_o,
      output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
      input  mem_rdata_o, mem_ack_o
   );
endinterface

// File: rtl/ram2_arbiter.sv
// ram2_arbiter: shares the external RAM2 asynchronous SRAM between the
// instruction-fetch (IF) and memory-stage (MEM) ports. Each access runs
// IDLE/HOLD -> SETUP -> STROBE -> HOLD with registered, active-low strobes.
// Arbitration at IDLE and HOLD: a lone request wins; on a tie the port not
// granted last wins (last-grant resets to IF).
// Optional feature macro RAM2_WAIT_EN: stretches STROBE by WAIT_CYCLES
// cycles using a 4-bit down-counter; without it STROBE is one cycle.
module ram2_arbiter #(
   parameter int unsigned ADDR_W      = 18,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   ram2_arbiter_if.slave     bus,
   output logic              busy_o,
   output logic [ADDR_W-1:0] Ram2Addr_o,
   inout  wire  [DATA_W-1:0] Ram2Data_io,
   output logic              Ram2OE_o,
   output logic              Ram2WE_o,
   output logic              Ram2EN_o
);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_range
      $error("ram2_arbiter: WAIT_CYCLES must lie in 1..15");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_e;

   state_e            state_q,     state_d;
   logic              last_mem_q,  last_mem_d;   // port granted last: 1 = MEM
   logic              sel_mem_q,   sel_mem_d;    // port owning the running access
   logic              we_q,        we_d;         // running access is a write
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic              en_n_q,      en_n_d;
   logic              oe_n_q,      oe_n_d;
   logic              we_n_q,      we_n_d;
   logic              drive_q,     drive_d;
   logic              if_ack_q,    if_ack_d;
   logic              mem_ack_q,   mem_ack_d;
   logic [DATA_W-1:0] if_data_q,   if_data_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

   logic strobe_done;
   logic grant_any;
   logic grant_mem;

`ifdef RAM2_WAIT_EN
   localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

   logic [3:0] wait_q, wait_d;

   assign strobe_done = (wait_q == '0);

   // extra-strobe counter: loaded while in SETUP so it is full on STROBE entry
   always_comb begin
      wait_d = wait_q;
      if (state_q == ST_SETUP) begin
         wait_d = WaitLoad;
      end else if (state_q == ST_STROBE && !strobe_done) begin
         wait_d = wait_q - 4'd1;
      end
   end

   // extra-strobe counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   assign strobe_done = 1'b1;
`endif

   assign grant_any = bus.if_req_i | bus.mem_req_i;
   assign grant_mem = bus.mem_req_i & (~bus.if_req_i | ~last_mem_q);

   // next state, grant latching, read capture, and next values of every
   // registered pin (pins are decoded from the next state so they are glitch-free flops)
   always_comb begin
      state_d     = state_q;
      last_mem_d  = last_mem_q;
      sel_mem_d   = sel_mem_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;

      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (grant_any) begin
               state_d    = ST_SETUP;
               last_mem_d = grant_mem;
               sel_mem_d  = grant_mem;
               we_d       = grant_mem & bus.mem_we_i;
               addr_d     = grant_mem ? bus.mem_addr_i : ADDR_W'(bus.if_addr_i);
               if (grant_mem) begin
                  wdata_d = bus.mem_wdata_i;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
         end
         ST_STROBE: begin
            if (strobe_done) begin
               state_d   = ST_HOLD;
               if_ack_d  = ~sel_mem_q;
               mem_ack_d = sel_mem_q;
               if (!we_q) begin
                  if (sel_mem_q) begin
                     mem_rdata_d = Ram2Data_io;
                  end else begin
                     if_data_d = Ram2Data_io;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      en_n_d  = (state_d == ST_IDLE);
      oe_n_d  = ~((state_d == ST_STROBE) & ~we_d);
      we_n_d  = ~((state_d == ST_STROBE) & we_d);
      drive_d = (state_d != ST_IDLE) & we_d;
   end

   // state, grant bookkeeping and all registered outputs; reset releases the pins at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         last_mem_q  <= 1'b0;
         sel_mem_q   <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         en_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         drive_q     <= 1'b0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_mem_q  <= last_mem_d;
         sel_mem_q   <= sel_mem_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         en_n_q      <= en_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         drive_q     <= drive_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign Ram2Addr_o  = addr_q;
   assign Ram2EN_o    = en_n_q;
   assign Ram2OE_o    = oe_n_q;
   assign Ram2WE_o    = we_n_q;
   assign Ram2Data_io = drive_q ? wdata_q : 'z;

   assign busy_o          = (state_q != ST_IDLE);
   assign bus.if_ack_o    = if_ack_q;
   assign bus.if_data_o   = if_data_q;
   assign bus.mem_ack_o   = mem_ack_q;
   assign bus.mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Bench for ram2_arbiter: SRAM behavioural model on the Ram2 pins, a
// scoreboard of expected accesses (pushed on request, popped on ack),
// a table of single accesses plus hand sequences for ties and reset abort.
module tb_ram2_arbiter;
   localparam int unsigned AW = 18;
   localparam int unsigned DW = 16;
`ifdef RAM2_WAIT_EN
   localparam int unsigned W = 2;
`else
   localparam int unsigned W = 0;
`endif
   localparam int unsigned LAT = 3 + W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          busy;
   logic [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;
   logic          oe_n, we_n, en_n;

   ram2_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   ram2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus_if),
      .busy_o      (busy),
      .Ram2Addr_o  (ram_addr),
      .Ram2Data_io (ram_data),
      .Ram2OE_o    (oe_n),
      .Ram2WE_o    (we_n),
      .Ram2EN_o    (en_n)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- SRAM model ----------------
   logic [DW-1:0] sram [logic [AW-1:0]];
   logic [DW-1:0] sram_rd = '0;

   always @(negedge clk) begin
      if (sram.exists(ram_addr)) sram_rd = sram[ram_addr];
      else                       sram_rd = 16'hDEAD;
   end

   always @(posedge clk) begin
      if (rst && !en_n && !we_n) sram[ram_addr] = ram_data;
   end

   assign ram_data = (!en_n && !oe_n) ? sram_rd : 'z;

   // ---------------- checking ----------------
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit            is_mem;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int unsigned   ack_cyc;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] m_if_data  = '0;
   logic [DW-1:0] m_mem_data = '0;
   int unsigned   oe_lo = 0, we_lo = 0, drv_cnt = 0;
   bit            addr_bad = 1'b0;

   // scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         sb.delete();
         oe_lo = 0; we_lo = 0; drv_cnt = 0; addr_bad = 1'b0;
         m_if_data = '0; m_mem_data = '0;
      end else begin
         if (!oe_n) oe_lo++;
         if (!we_n) we_lo++;
         if (sb.size() != 0) begin
            if ((!oe_n || !we_n) && ram_addr !== sb[0].addr) addr_bad = 1'b1;
            if (!en_n && sb[0].we && ram_data === sb[0].data) drv_cnt++;
         end
         if (bus_if.if_ack_o || bus_if.mem_ack_o) begin
            if (sb.size() == 0) begin
               chk("spurious ack", {30'd0, bus_if.if_ack_o, bus_if.mem_ack_o}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack port", {30'd0, bus_if.if_ack_o, bus_if.mem_ack_o}, e.is_mem ? 32'd1 : 32'd2);
               chk("ack cycle", cyc, e.ack_cyc);
               chk("addr during strobe", {31'd0, addr_bad}, 32'd0);
               chk("OE low cycles", oe_lo, e.we ? 0 : 1 + W);
               chk("WE low cycles", we_lo, e.we ? 1 + W : 0);
               if (e.we) chk("bus drive cycles", drv_cnt, 3 + W);
               else if (e.is_mem) m_mem_data = e.data;
               else m_if_data = e.data;
               chk("if_data_o", {16'd0, bus_if.if_data_o}, {16'd0, m_if_data});
               chk("mem_rdata_o", {16'd0, bus_if.mem_rdata_o}, {16'd0, m_mem_data});
            end
            oe_lo = 0; we_lo = 0; drv_cnt = 0; addr_bad = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      bit            is_mem;
      bit            we;
      bit            preload;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } vec_t;

   vec_t vecs[8];

   task automatic do_access(input vec_t v);
      exp_t        e;
      bit          got;
      int unsigned t;
      if (v.preload) sram[v.addr] = v.data;
      e.is_mem  = v.is_mem;
      e.we      = v.we;
      e.addr    = v.addr;
      e.data    = v.data;
      e.ack_cyc = cyc + LAT;
      sb.push_back(e);
      if (v.is_mem) begin
         bus_if.mem_addr_i  = v.addr;
         bus_if.mem_we_i    = v.we;
         bus_if.mem_wdata_i = v.data;
         bus_if.mem_req_i   = 1'b1;
      end else begin
         bus_if.if_addr_i = v.addr[15:0];
         bus_if.if_req_i  = 1'b1;
      end
      got = 1'b0;
      t   = 0;
      while (!got && t < 40) begin
         @(negedge clk);
         t++;
         got = v.is_mem ? bus_if.mem_ack_o : bus_if.if_ack_o;
      end
      bus_if.mem_req_i = 1'b0;
      bus_if.if_req_i  = 1'b0;
      chk("ack seen", {31'd0, got}, 32'd1);
   endtask

   // both ports request together and each holds until its n-th ack
   task automatic run_pair(input int unsigned n, input logic [AW-1:0] ma, input logic [15:0] ia,
                           input logic [DW-1:0] md, input logic [DW-1:0] id);
      exp_t        e;
      int unsigned mem_n, if_n, busy_lo, t;
      sram[ma]     = md;
      sram[AW'(ia)] = id;
      for (int unsigned k = 0; k < 2 * n; k++) begin
         e.is_mem  = (k % 2 == 0);
         e.we      = 1'b0;
         e.addr    = e.is_mem ? ma : AW'(ia);
         e.data    = e.is_mem ? md : id;
         e.ack_cyc = cyc + LAT * (k + 1);
         sb.push_back(e);
      end
      bus_if.mem_addr_i = ma;
      bus_if.mem_we_i   = 1'b0;
      bus_if.if_addr_i  = ia;
      bus_if.mem_req_i  = 1'b1;
      bus_if.if_req_i   = 1'b1;
      mem_n = 0; if_n = 0; busy_lo = 0; t = 0;
      while ((mem_n < n || if_n < n) && t < 40 * n) begin
         @(negedge clk);
         t++;
         if (!busy) busy_lo++;
         if (bus_if.mem_ack_o) begin
            mem_n++;
            if (mem_n == n) bus_if.mem_req_i = 1'b0;
         end
         if (bus_if.if_ack_o) begin
            if_n++;
            if (if_n == n) bus_if.if_req_i = 1'b0;
         end
      end
      bus_if.mem_req_i = 1'b0;
      bus_if.if_req_i  = 1'b0;
      chk("pair mem acks", mem_n, n);
      chk("pair if acks", if_n, n);
      chk("pair busy gaps", busy_lo, 0);
      @(negedge clk);
      chk("pair back to idle", {31'd0, busy}, 32'd0);
      chk("pair scoreboard drained", sb.size(), 0);
   endtask

   initial begin
      bit          got;
      int unsigned t, acks;
      vec_t        v;

      bus_if.if_req_i    = 1'b0;
      bus_if.if_addr_i   = '0;
      bus_if.mem_req_i   = 1'b0;
      bus_if.mem_we_i    = 1'b0;
      bus_if.mem_addr_i  = '0;
      bus_if.mem_wdata_i = '0;

      //            is_mem we  pre  addr        data
      vecs[0] = '{1'b0, 1'b0, 1'b1, 18'h00040, 16'h1234};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 18'h20010, 16'hBEEF};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 18'h20010, 16'hBEEF};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 18'h3FFFF, 16'h5A5A};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 18'h0FFFF, 16'h0F0F};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 18'h00000, 16'hA5C3};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 18'h00000, 16'hA5C3};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 18'h12345, 16'h8001};

      #2 rst = 1'b0;
      repeat (3) @(negedge clk);

      chk("reset EN", {31'd0, en_n}, 32'd1);
      chk("reset OE", {31'd0, oe_n}, 32'd1);
      chk("reset WE", {31'd0, we_n}, 32'd1);
      chk("reset addr", {14'd0, ram_addr}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset if_ack", {31'd0, bus_if.if_ack_o}, 32'd0);
      chk("reset mem_ack", {31'd0, bus_if.mem_ack_o}, 32'd0);
      chk("reset if_data", {16'd0, bus_if.if_data_o}, 32'd0);
      chk("reset mem_rdata", {16'd0, bus_if.mem_rdata_o}, 32'd0);

      // tie in the first cycle after reset: MEM first, IF straight after
      rst = 1'b1;
      run_pair(1, 18'h2ABCD, 16'h0123, 16'h1111, 16'h2222);

      // both held for four accesses: MEM, IF, MEM, IF
      @(negedge clk);
      run_pair(2, 18'h2ABCD, 16'h0123, 16'h3333, 16'h4444);

      // single accesses from IDLE
      for (int unsigned i = 0; i < 8; i++) begin
         @(negedge clk);
         v = vecs[i];
         do_access(v);
         if (v.we) begin
            @(negedge clk);
            chk($sformatf("vec%0d bus released", i), {31'd0, ram_data === v.data}, 32'd0);
            chk($sformatf("vec%0d EN idle", i), {31'd0, en_n}, 32'd1);
            chk($sformatf("vec%0d sram word", i), {16'd0, sram[v.addr]}, {16'd0, v.data});
         end
      end

      // reset while a write is strobing
      @(negedge clk);
      bus_if.mem_addr_i  = 18'h00100;
      bus_if.mem_we_i    = 1'b1;
      bus_if.mem_wdata_i = 16'h7E7E;
      bus_if.mem_req_i   = 1'b1;
      got = 1'b0;
      t   = 0;
      while (!got && t < 20) begin
         @(negedge clk);
         t++;
         got = !we_n;
      end
      chk("abort strobe reached", {31'd0, got}, 32'd1);
      bus_if.mem_req_i = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("abort WE released", {31'd0, we_n}, 32'd1);
      chk("abort OE released", {31'd0, oe_n}, 32'd1);
      chk("abort EN released", {31'd0, en_n}, 32'd1);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort bus released", {31'd0, ram_data === 16'h7E7E}, 32'd0);
      repeat (2) @(negedge clk);
      rst  = 1'b1;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus_if.mem_ack_o || bus_if.if_ack_o) acks++;
      end
      chk("abort no ack", acks, 0);
      chk("abort idle", {31'd0, busy}, 32'd0);

      // fresh access after the abort
      v = '{1'b1, 1'b0, 1'b0, 18'h00040, 16'h1234};
      do_access(v);
      repeat (2) @(negedge clk);
      chk("final scoreboard drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
